// File: rtl/res_alloc_pkg.sv
// res_alloc_pkg: resource-pool sizing and index/mask types shared by the allocator and its release side.
package res_alloc_pkg;
   localparam int NUM_PHYS_RES = 64;
   localparam int RES_IDX_W = $clog2(NUM_PHYS_RES);
   typedef logic [RES_IDX_W-1:0] res_idx_t;
   typedef logic [NUM_PHYS_RES-1:0] res_mask_t;
endpackage

// File: rtl/release_decoder.sv
// release_decoder: decodes per-lane release indices to one-hot masks and flags lanes repeating a lower lane's index.
module release_decoder
   import res_alloc_pkg::*;
#(
   parameter int N = 3,
   parameter int W = RES_IDX_W,
   parameter int R = NUM_PHYS_RES
) (
   input  logic [N-1:0]        valid,
   input  logic [N-1:0][W-1:0] idx,
   output logic [N-1:0][R-1:0] onehot,
   output logic [N-1:0]        dup
);
   always_comb begin
      onehot = '0;
      dup = '0;
      for (int k = 0; k < N; k++) begin
         onehot[k] = valid[k] ? R'(1) << idx[k] : '0;
         for (int j = 0; j < k; j++)
            if (valid[j] && valid[k] && idx[j] == idx[k]) dup[k] = 1'b1;
      end
   end
endmodule

// File: rtl/resource_release_unit.sv
// resource_release_unit: turns encoded releases into a registered one-hot clear vector for the allocator,
// tracking held resources from the grant bus and flagging illegal releases and conflicting grants.
module resource_release_unit
   import res_alloc_pkg::*;
#(
   parameter int NUM_RESOURCES = NUM_PHYS_RES,
   parameter int NUM_RELEASES = 3,
   parameter int NUM_REQUESTS = 3,
   parameter int IDX_W = $clog2(NUM_RESOURCES),
   localparam int CNT_W = $clog2(NUM_RESOURCES + 1)
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [NUM_RELEASES-1:0]                   rel_valid,
   input  logic [NUM_RELEASES-1:0][IDX_W-1:0]        rel_idx,
   input  logic                                      hold,
   input  logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0] grant,
   output logic [NUM_RESOURCES-1:0]                  clear,
   output logic [CNT_W-1:0]                          in_use_count,
   output logic                                      err_release,
   output logic                                      err_grant,
   output logic                                      err_sticky
);
   logic [NUM_RESOURCES-1:0] in_use, pending, clear_q, new_rel, grant_any, in_use_next;
   logic [NUM_RELEASES-1:0][NUM_RESOURCES-1:0] onehot;
   logic [NUM_RELEASES-1:0] dup;
   logic bad_release, bad_grant;
   logic [CNT_W-1:0] count_next;

   release_decoder #(.N(NUM_RELEASES), .W(IDX_W), .R(NUM_RESOURCES)) decoder (
      .valid(rel_valid), .idx(rel_idx), .onehot(onehot), .dup(dup)
   );

   // A lane is legal only for a held resource not already on its way out.
   always_comb begin
      new_rel = '0;
      bad_release = 1'b0;
      for (int k = 0; k < NUM_RELEASES; k++)
         if (rel_valid[k]) begin
            if (!dup[k] && |(onehot[k] & in_use & ~clear_q & ~pending)) new_rel = new_rel | onehot[k];
            else bad_release = 1'b1;
         end
   end

   always_comb begin
      grant_any = '0;
      for (int r = 0; r < NUM_REQUESTS; r++) grant_any = grant_any | grant[r];
   end

   assign bad_grant = |(grant_any & in_use & ~clear_q);
   assign in_use_next = (in_use & ~clear_q) | grant_any;

   always_comb begin
      count_next = '0;
      for (int i = 0; i < NUM_RESOURCES; i++) count_next = count_next + CNT_W'(in_use_next[i]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_use <= '0;
         pending <= '0;
         clear_q <= '0;
         in_use_count <= '0;
         err_release <= 1'b0;
         err_grant <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         clear_q <= hold ? '0 : pending | new_rel;
         pending <= hold ? pending | new_rel : '0;
         in_use <= in_use_next;
         in_use_count <= count_next;
         err_release <= bad_release;
         err_grant <= bad_grant;
         err_sticky <= err_sticky | bad_release | bad_grant;
      end
   end

   assign clear = clear_q;
endmodule

// File: tb/tb_resource_release_unit.sv
// tb_resource_release_unit: scoreboard bench; a reference model pushes expected outputs per driven cycle.
module tb_resource_release_unit;
   logic clock = 1'b0;
   logic reset;
   logic [2:0] rel_valid;
   logic [2:0][5:0] rel_idx;
   logic hold;
   logic [2:0][63:0] grant;
   logic [63:0] clear;
   logic [6:0] in_use_count;
   logic err_release, err_grant, err_sticky;

   resource_release_unit dut (
      .clock(clock), .reset(reset), .rel_valid(rel_valid), .rel_idx(rel_idx), .hold(hold),
      .grant(grant), .clear(clear), .in_use_count(in_use_count), .err_release(err_release),
      .err_grant(err_grant), .err_sticky(err_sticky)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [63:0] clr;
      logic [6:0]  cnt;
      logic        er, eg, es;
   } exp_t;

   exp_t sb[$];
   logic [63:0] m_in_use = '0, m_pend = '0, m_clr = '0;
   logic m_sticky = 1'b0;
   int errors = 0, checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b0;
      rel_valid = '0;
      rel_idx = '0;
      hold = 1'b0;
      grant = '0;
   endtask

   task automatic rel(input int lane, input int idx);
      rel_valid[lane] = 1'b1;
      rel_idx[lane] = 6'(idx);
   endtask

   task automatic step();
      exp_t e;
      logic [63:0] nr, ga;
      logic bad, dup;
      e = '0;
      if (reset) begin
         m_in_use = '0;
         m_pend = '0;
         m_clr = '0;
         m_sticky = 1'b0;
      end else begin
         nr = '0;
         bad = 1'b0;
         for (int k = 0; k < 3; k++)
            if (rel_valid[k]) begin
               dup = 1'b0;
               for (int j = 0; j < k; j++)
                  if (rel_valid[j] && rel_idx[j] == rel_idx[k]) dup = 1'b1;
               if (m_in_use[rel_idx[k]] && !m_clr[rel_idx[k]] && !m_pend[rel_idx[k]] && !dup)
                  nr[rel_idx[k]] = 1'b1;
               else bad = 1'b1;
            end
         ga = grant[0] | grant[1] | grant[2];
         e.eg = |(ga & m_in_use & ~m_clr);
         e.er = bad;
         m_in_use = (m_in_use & ~m_clr) | ga;
         e.clr = hold ? '0 : m_pend | nr;
         m_pend = hold ? m_pend | nr : '0;
         m_clr = e.clr;
         m_sticky = m_sticky | bad | e.eg;
         e.es = m_sticky;
         e.cnt = 7'($countones(m_in_use));
      end
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) check("sb_empty", 64'd1, 64'd0);
      else begin
         e = sb.pop_front();
         check("sb_clear", clear, e.clr);
         check("sb_count", 64'(in_use_count), 64'(e.cnt));
         check("sb_err_release", 64'(err_release), 64'(e.er));
         check("sb_err_grant", 64'(err_grant), 64'(e.eg));
         check("sb_err_sticky", 64'(err_sticky), 64'(e.es));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      check("rst_clear", clear, 64'd0);
      check("rst_count", 64'(in_use_count), 64'd0);
      check("rst_sticky", 64'(err_sticky), 64'd0);
      idle();
      grant[0] = 64'd1 << 5;
      grant[1] = 64'd1 << 9;
      step();
      check("grant_count", 64'(in_use_count), 64'd2);
      idle();
      rel(0, 5);
      step();
      check("rel5_clear", clear, 64'h20);
      check("rel5_count_hold", 64'(in_use_count), 64'd2);
      idle();
      step();
      check("rel5_clear_off", clear, 64'd0);
      check("rel5_count", 64'(in_use_count), 64'd1);
      grant[0] = 64'd1 << 1;
      grant[1] = 64'd1 << 2;
      grant[2] = 64'd1 << 3;
      step();
      for (int i = 1; i <= 3; i++) begin
         idle();
         hold = 1'b1;
         rel(0, i);
         step();
         check("held_clear", clear, 64'd0);
      end
      idle();
      step();
      check("flush_clear", clear, 64'hE);
      step();
      check("flush_once", clear, 64'd0);
      rel(0, 7);
      step();
      check("bad_err", 64'(err_release), 64'd1);
      check("bad_clear", clear, 64'd0);
      check("bad_sticky", 64'(err_sticky), 64'd1);
      idle();
      step();
      check("bad_pulse_end", 64'(err_release), 64'd0);
      grant[0] = 64'd1 << 4;
      step();
      idle();
      rel(0, 4);
      rel(2, 4);
      step();
      check("dup_clear", clear, 64'h10);
      check("dup_err", 64'(err_release), 64'd1);
      idle();
      grant[1] = 64'd1 << 6;
      step();
      step();
      check("regrant_err", 64'(err_grant), 64'd1);
      idle();
      rel(0, 6);
      step();
      idle();
      grant[2] = 64'd1 << 6;
      step();
      check("recycle_no_err", 64'(err_grant), 64'd0);
      idle();
      step();
      grant[0] = 64'd1 << 10;
      grant[1] = 64'd1 << 11;
      step();
      idle();
      hold = 1'b1;
      rel(0, 10);
      rel(1, 11);
      step();
      idle();
      hold = 1'b1;
      reset = 1'b1;
      step();
      check("midrst_clear", clear, 64'd0);
      check("midrst_count", 64'(in_use_count), 64'd0);
      idle();
      step();
      check("midrst_discard", clear, 64'd0);
      for (int n = 0; n < 400; n++) begin
         idle();
         reset = ($urandom_range(0, 99) == 0);
         hold = ($urandom_range(0, 3) == 0);
         for (int r = 0; r < 3; r++)
            if ($urandom_range(0, 2) == 0) grant[r] = 64'd1 << $urandom_range(0, 15);
         for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 1) == 0) rel(k, $urandom_range(0, 15));
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/resource_release_unit.md
# resource_release_unit

Collects resource-release requests (e.g. freed physical registers or queue slots from retirement) as encoded indices and drives the one-hot, per-resource `clear` vector consumed by the resource allocator. It tracks which resources are currently held by observing the allocator's `grant` bus, buffers releases while `hold` is asserted, and flags illegal releases and conflicting grants. It sits between the commit/retire stage and the allocator, on the freeing side of the allocation protocol.

## Interface
- `NUM_RESOURCES`, 64, number of tracked resources; must match the allocator.
- `NUM_RELEASES`, 3, release lanes per cycle (retire width).
- `NUM_REQUESTS`, 3, allocator grant lanes observed.
- `IDX_W`, `$clog2(NUM_RESOURCES)`, release index width.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rel_valid`  in  `[NUM_RELEASES]`  lane k presents a release this cycle.
- `rel_idx`  in  `[NUM_RELEASES][IDX_W]`  index released on lane k.
- `hold`  in  1  defer driving `clear`; releases accumulate in the pending buffer.
- `grant`  in  `[NUM_REQUESTS][NUM_RESOURCES]`  allocator grant bus, one-hot or zero per lane.
- `clear`  out  `[NUM_RESOURCES]`  registered release vector to the allocator.
- `in_use_count`  out  `$clog2(NUM_RESOURCES+1)`  registered popcount of `in_use`.
- `err_release`  out  1  one-cycle pulse: an illegal release was dropped.
- `err_grant`  out  1  one-cycle pulse: a grant targeted a resource still in use.
- `err_sticky`  out  1  OR of all errors since reset.

## Operation
- State:
  - `in_use[NUM_RESOURCES]` is 1 while the resource is held.
  - `pending[NUM_RESOURCES]` holds releases accepted but not yet driven on `clear`.
  - `clear_q` drives `clear`.
- Acceptance per lane k with `rel_valid[k]`, index i:
  - Legal if `in_use[i] & ~clear_q[i] & ~pending[i]`, and no lower lane carries the same i.
  - Otherwise the lane is dropped and `err_release` pulses next cycle.
  - `new_rel` is the OR of the one-hot decodes of all legal lanes.
- `grant_any` is the OR of all `grant` lanes.
- Register updates on each clock edge:
  - `hold`=0: `clear_q <= pending | new_rel`, and `pending <= 0`.
  - `hold`=1: `clear_q <= 0`, and `pending <= pending | new_rel`.
  - `in_use <= (in_use & ~clear_q) | grant_any`.
  - `err_grant` pulses if `grant_any & in_use & ~clear_q` is non-zero.
  - `in_use_count` is the popcount of the next `in_use` value, registered.
- Releasing a resource granted in the same cycle is illegal, because `in_use` is not yet set.
- A release of i while `clear_q[i]` is high is illegal (double free).
- Multiple errors in one cycle produce a single pulse.
- Reset:
  - `in_use`, `pending`, `clear_q` are all 0, and `in_use_count` is 0.
  - All error outputs are 0.
  - A mid-operation reset discards pending releases; this is consistent with the allocator resetting to all-free.

## Timing
- Release sampled at edge t (with `hold` low) drives `clear` during cycle t+1. The allocator marks the resource free at edge t+2.
- `in_use[i]` drops at edge t+2 (the same edge the allocator consumes `clear`), so `clear` and `in_use` never disagree across a cycle boundary.
- Held releases appear on `clear` together, in the cycle after the first edge that samples `hold`=0. There is no rate limit, because `clear` is a vector.
- `clear` is high for exactly one cycle per accepted release.
- Grant sampled at edge t sets `in_use` from cycle t+1. `in_use_count` reflects it from cycle t+1.
- Errors pulse in cycle t+1 for stimulus sampled at edge t.
- No combinational path from any input to any output.

## Structure
- Shared package `res_alloc_pkg`:
  - `NUM_PHYS_RES`, `RES_IDX_W` constants.
  - `res_idx_t` typedef.
  - `res_mask_t` typedef (`logic [NUM_PHYS_RES-1:0]`).
  - Parameters default to the package values.
- Sub-module `release_decoder` (combinational):
  - N encoded indices plus valids in, per-lane one-hot masks out.
  - Also outputs a per-lane duplicate-of-lower-lane flag.
  - Instantiated once; legality qualification stays in the top.

## Test plan
- Reset; grant lanes give resources 5 and 9; release 5 on lane 0 -> `clear` = bit 5 only, one cycle later; `in_use_count` goes 2 -> 1 two cycles after the release.
- Grant 1, 2, 3; assert `hold`; release 1, then 2, then 3 over three cycles -> `clear` = 0 throughout; drop `hold` -> `clear` = bits 1, 2, 3 for exactly one cycle.
- Release 7 while not in use -> `err_release` one-cycle pulse, `clear` stays 0, `err_sticky` = 1.
- Lanes 0 and 2 both release in-use index 4 -> `clear` = bit 4 once, `err_release` pulses.
- Grant resource 6 while `in_use[6]`=1 and not clearing -> `err_grant` pulses; grant 6 in the cycle `clear[6]` is high -> no error, `in_use[6]` stays 1.
- Hold with pending bits 10 and 11, then `reset` -> `clear` = 0, `in_use_count` = 0, pending discarded after `hold` drops.
